// File: rtl/alu_bist_pkg.sv
// rtl/alu_bist_pkg.sv - shared types and constants for the ALU self-test block
package alu_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] ALU_B_MASK   = 32'h5A5A_5A5A;

    // Operand-B scramble mask bit for any operand width; the 32-bit pattern repeats.
    function automatic logic mask_bit(input int idx);
        return ALU_B_MASK[5'(idx % 32)];
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - Galois shift register with load, enable and parallel XOR input
// Right-shifting it is a pattern generator; left-shifting with din it is a MISR.
module bist_lfsr
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
    parameter bit               SHIFT_LEFT = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = '0;
        if (SHIFT_LEFT) begin
            shifted = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
        end else begin
            shifted = {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= shifted ^ din;
        end
    end

endmodule

// File: rtl/alu_bist.sv
// rtl/alu_bist.sv - ALU self-test initiator: LFSR operand sweep, MISR response compaction
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               SEL_SZ   = 4,
    parameter int               NUM_OPS  = 10,
    parameter int               PATTERNS = 16,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(32'h0000_0001),
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(DEFAULT_TAPS),
    parameter logic [WIDTH-1:0] GOLDEN   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [SEL_SZ-1:0] alu_sel,
    input  logic [WIDTH-1:0]  alu_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [WIDTH-1:0]  signature
);

    localparam logic [WIDTH-1:0]  SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam int                PAT_W    = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
    localparam logic [SEL_SZ-1:0] LAST_SEL = SEL_SZ'(NUM_OPS - 1);
    localparam logic [PAT_W-1:0]  LAST_PAT = PAT_W'(PATTERNS - 1);
    localparam int                HALF     = WIDTH / 2;

    state_t           state;
    state_t           state_n;
    logic [PAT_W-1:0] pattern;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] misr;
    logic [WIDTH-1:0] b_mask;
    logic             running;
    logic             launch;
    logic             wrap;
    logic             last;
    logic             advance;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
        assign b_mask[i] = mask_bit(i);
    end

    always_comb begin
        running = (state == RUN);
        launch  = start && !running;
        wrap    = running && (alu_sel == LAST_SEL);
        last    = wrap && (pattern == LAST_PAT);
        advance = wrap && !last;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start) state_n = RUN;
            RUN:        if (last)  state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The final vector is held on the bus after completion, so the last edge does not advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_sel <= '0;
            pattern <= '0;
        end else if (launch) begin
            alu_sel <= '0;
            pattern <= '0;
        end else if (advance) begin
            alu_sel <= '0;
            pattern <= pattern + 1'b1;
        end else if (running && !wrap) begin
            alu_sel <= alu_sel + 1'b1;
        end
    end

    bist_lfsr #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .SHIFT_LEFT (1'b0),
        .RESET_VAL  (SEED_EFF)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (launch),
        .load_val (SEED_EFF),
        .en       (advance),
        .din      ('0),
        .q        (lfsr)
    );

    bist_lfsr #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .SHIFT_LEFT (1'b1),
        .RESET_VAL  ('0)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (launch),
        .load_val ('0),
        .en       (running),
        .din      (alu_out),
        .q        (misr)
    );

    // IDLE is only reachable through reset, so it marks "no test launched yet".
    assign alu_a     = (state == IDLE) ? '0 : lfsr;
    assign alu_b     = (state == IDLE) ? '0 : ({lfsr[HALF-1:0], lfsr[WIDTH-1:HALF]} ^ b_mask);
    assign busy      = running;
    assign done      = (state == DONE);
    assign pass      = done && (misr == GOLDEN);
    assign signature = misr;

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Hardware self-test initiator for the MIPS ALU: drives the ALU's A, B and ALU_Sel inputs and consumes its ALU_Out.
- Sweeps operand pairs from an LFSR across every ALU operation, compresses results into a MISR signature, and flags pass/fail against a golden value.
- Sits beside the datapath ALU and is muxed onto its inputs during test; it is the stimulus/response end of the ALU interface.

Parameters:
- WIDTH, 32, operand/result width (must be even)
- SEL_SZ, 4, ALU_Sel width
- NUM_OPS, 10, opcodes swept: 0..NUM_OPS-1
- PATTERNS, 16, operand pairs generated
- SEED, 32'h0000_0001, LFSR start value; 0 is replaced by 1
- TAPS, 32'h8020_0003, feedback mask shared by LFSR and MISR
- GOLDEN, 32'h0000_0000, expected final signature

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a test; sampled in IDLE or DONE only
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_sel  out  SEL_SZ  to ALU_Sel
- alu_out  in  WIDTH  from ALU_Out (combinational from alu_a/alu_b/alu_sel)
- busy  out  1  high in RUN
- done  out  1  sticky completion flag
- pass  out  1  valid when done; 1 = signature matched GOLDEN
- signature  out  WIDTH  current/final MISR value

Behaviour:
- Reset: state IDLE; all outputs 0; lfsr=SEED (or 1), misr=0, sel/pattern counters 0. Reset mid-RUN aborts immediately with the same values.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge k: state<-RUN, lfsr<-SEED, misr<-0, alu_sel<-0, pattern<-0, done<-0, pass<-0, busy<-1.
- RUN, each edge: misr<-misr_next(alu_out) absorbs the vector currently driven.
  - If alu_sel<NUM_OPS-1: alu_sel<-alu_sel+1.
  - Else: alu_sel<-0; lfsr steps; pattern<-pattern+1.
- Operands (registered, follow lfsr): alu_a = lfsr; alu_b = {lfsr[WIDTH/2-1:0], lfsr[WIDTH-1:WIDTH/2]} ^ {WIDTH/8{4'h5A... pattern}}, i.e. half-swap XOR 0x5A5A_5A5A at WIDTH=32.
- LFSR step (Galois): lfsr <- (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
- MISR step: misr <- ({misr[WIDTH-2:0],1'b0} ^ (misr[WIDTH-1] ? TAPS : 0)) ^ alu_out.
- Termination: on the edge absorbing the last vector (pattern=PATTERNS-1, alu_sel=NUM_OPS-1), state<-DONE, busy<-0, done<-1, pass<-(misr_next==GOLDEN).
- Latency: done rises exactly N = PATTERNS*NUM_OPS edges after the start edge.
- start while RUN: ignored. start in DONE: restarts and clears done/pass on that edge.
- DONE: done, pass, signature and the last alu_a/alu_b/alu_sel are held until start or rst.
- signature = misr at all times.
- Widths: all arithmetic is modulo WIDTH; counters are sized from clog2 of NUM_OPS and PATTERNS.

Decomposition:
- Shared package alu_bist_pkg:
  - state enum {IDLE, RUN, DONE}
  - default TAPS constant
  - ALU_B_MASK constant 32'h5A5A_5A5A
- One sub-module bist_lfsr: WIDTH/TAPS Galois shift register with enable, load value and parallel XOR input.
  - Instantiated twice: LFSR with din=0, and MISR with din=alu_out.

Test Plan:
- Reset: assert rst mid-idle -> all outputs 0. Assert rst at RUN cycle 5 -> busy=0, done=0, alu_sel=0 within the same cycle (async).
- Minimal config (PATTERNS=1, NUM_OPS=1, SEED=1), ALU stubbed as alu_out=alu_a, GOLDEN=1:
  - start -> alu_a=0x00000001, alu_b=0x5A5B5A5A.
  - done=1 one edge later, signature=0x00000001, pass=1.
- Default config vs. behavioural ALU model, GOLDEN from bench model:
  - done exactly 160 edges after start, pass=1.
  - alu_sel sequence 0..9 repeated 16 times.
  - lfsr steps only on the 9->0 wrap.
- Fault injection: same run with alu_out[0] forced 0 -> pass=0, done=1 at the same cycle, signature differs from GOLDEN.
- start pulsed at RUN cycles 3 and 50 -> no restart, done still at edge 160. start in DONE -> done/pass clear, second run reproduces an identical signature.
- SEED=0 -> behaves identically to SEED=1 (first alu_a=0x00000001).
